// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: single-cycle ALU plus iterative multu with HI/LO
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   valid_in                         ID/EX bundle holds a real instruction
//   ALUOp_in, funct_in, shamt_in     operation select (00 add, 01 sub, 10 R-type, 11 or)
//   RsData_in, RtData_in             source operands
//   RdAddr_in, RegWrite_in           destination register and write request
//   stall_out                        high while the multiplier is busy
//   Result_out, RdAddr_out,
//   RegWrite_out                     registered EX/WB bundle
module ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [1:0]            ALUOp_in,
    input  logic [5:0]            funct_in,
    input  logic [4:0]            shamt_in,
    input  logic [DATA_W-1:0]     RsData_in,
    input  logic [DATA_W-1:0]     RtData_in,
    input  logic [REG_ADDR_W-1:0] RdAddr_in,
    input  logic                  RegWrite_in,
    output logic                  stall_out,
    output logic [DATA_W-1:0]     Result_out,
    output logic [REG_ADDR_W-1:0] RdAddr_out,
    output logic                  RegWrite_out
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DATA_W - 1);

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2A;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    logic [CNT_W-1:0]    count;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
    logic [DATA_W-1:0]   mcand;
    // Upper half accumulates partial sums; lower half holds the not-yet-consumed
    // multiplier bits and fills with product bits as it shifts right.
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] prod_next;
    logic [DATA_W:0]     partial;

    logic [DATA_W-1:0]   alu_result;
    logic                alu_ok;
    logic                is_multu;

    assign stall_out = (state == BUSY);

    always_comb begin
        alu_result = '0;
        alu_ok     = 1'b0;
        is_multu   = 1'b0;
        case (ALUOp_in)
            2'b00: begin
                alu_result = RsData_in + RtData_in;
                alu_ok     = 1'b1;
            end
            2'b01: begin
                alu_result = RsData_in - RtData_in;
                alu_ok     = 1'b1;
            end
            2'b11: begin
                alu_result = RsData_in | RtData_in;
                alu_ok     = 1'b1;
            end
            default: begin
                alu_ok = 1'b1;
                case (funct_in)
                    F_ADD:   alu_result = RsData_in + RtData_in;
                    F_SUB:   alu_result = RsData_in - RtData_in;
                    F_AND:   alu_result = RsData_in & RtData_in;
                    F_OR:    alu_result = RsData_in | RtData_in;
                    F_SLT:   alu_result = {{(DATA_W-1){1'b0}},
                                           ($signed(RsData_in) < $signed(RtData_in))};
                    F_SLL:   alu_result = RtData_in << shamt_in;
                    F_SRL:   alu_result = RtData_in >> shamt_in;
                    F_MFHI:  alu_result = hi;
                    F_MFLO:  alu_result = lo;
                    F_MULTU: begin
                        alu_ok   = 1'b0;
                        is_multu = 1'b1;
                    end
                    default: alu_ok = 1'b0;
                endcase
            end
        endcase
    end

    // One shift-add iteration: conditionally add the multiplicand into the
    // upper half (keeping the carry), then shift the whole product right.
    always_comb begin
        partial   = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_next = {partial, prod[DATA_W-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= '0;
            hi           <= '0;
            lo           <= '0;
            mcand        <= '0;
            prod         <= '0;
            Result_out   <= '0;
            RdAddr_out   <= '0;
            RegWrite_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        if (is_multu) begin
                            state        <= BUSY;
                            count        <= '0;
                            mcand        <= RsData_in;
                            prod         <= {{DATA_W{1'b0}}, RtData_in};
                            RegWrite_out <= 1'b0;
                        end else begin
                            Result_out   <= alu_ok ? alu_result : '0;
                            RdAddr_out   <= RdAddr_in;
                            RegWrite_out <= RegWrite_in & alu_ok;
                        end
                    end else begin
                        RegWrite_out <= 1'b0;
                    end
                end
                BUSY: begin
                    RegWrite_out <= 1'b0;
                    prod         <= prod_next;
                    if (count == LAST_COUNT) begin
                        hi    <= prod_next[2*DATA_W-1:DATA_W];
                        lo    <= prod_next[DATA_W-1:0];
                        count <= '0;
                        state <= IDLE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [1:0]  ALUOp_in;
    logic [5:0]  funct_in;
    logic [4:0]  shamt_in;
    logic [31:0] RsData_in;
    logic [31:0] RtData_in;
    logic [4:0]  RdAddr_in;
    logic        RegWrite_in;
    logic        stall_out;
    logic [31:0] Result_out;
    logic [4:0]  RdAddr_out;
    logic        RegWrite_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .ALUOp_in     (ALUOp_in),
        .funct_in     (funct_in),
        .shamt_in     (shamt_in),
        .RsData_in    (RsData_in),
        .RtData_in    (RtData_in),
        .RdAddr_in    (RdAddr_in),
        .RegWrite_in  (RegWrite_in),
        .stall_out    (stall_out),
        .Result_out   (Result_out),
        .RdAddr_out   (RdAddr_out),
        .RegWrite_out (RegWrite_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Drive one bundle away from the edge, then sample just after the edge.
    task automatic step(input logic v, input logic [1:0] op, input logic [5:0] fn,
                        input logic [4:0] sh, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [4:0] rd, input logic rw);
        @(negedge clk);
        valid_in    = v;
        ALUOp_in    = op;
        funct_in    = fn;
        shamt_in    = sh;
        RsData_in   = rs;
        RtData_in   = rt;
        RdAddr_in   = rd;
        RegWrite_in = rw;
        @(posedge clk);
        #1;
    endtask

    task automatic rtype(input logic [5:0] fn, input logic [4:0] sh, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [4:0] rd);
        step(1'b1, 2'b10, fn, sh, rs, rt, rd, 1'b1);
    endtask

    task automatic bubble();
        step(1'b0, 2'b10, 6'h20, 5'd0, 32'hDEAD_BEEF, 32'h1, 5'd31, 1'b1);
    endtask

    // Holds a live add on the inputs while stalled; it must be ignored.
    task automatic run_multu(input string tag, input logic [31:0] rs, input logic [31:0] rt);
        int n;
        int rw_seen;
        rtype(6'h19, 5'd0, rs, rt, 5'd9);
        check({tag, "_accept_rw"}, 32'(RegWrite_out), 32'd0);
        n = 0;
        rw_seen = 0;
        valid_in  = 1'b1;
        ALUOp_in  = 2'b00;
        RegWrite_in = 1'b1;
        while (stall_out && n < 40) begin
            n++;
            @(posedge clk);
            #1;
            if (RegWrite_out) rw_seen++;
        end
        check({tag, "_stall_cycles"}, 32'(n), 32'd32);
        check({tag, "_busy_rw"}, 32'(rw_seen), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        valid_in = 1'b0; ALUOp_in = 2'b00; funct_in = 6'h0; shamt_in = 5'd0;
        RsData_in = '0; RtData_in = '0; RdAddr_in = '0; RegWrite_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", Result_out, 32'h0);
        check("rst_rd", 32'(RdAddr_out), 32'h0);
        check("rst_rw", 32'(RegWrite_out), 32'h0);
        check("rst_stall", 32'(stall_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        rtype(6'h20, 5'd0, 32'd5, 32'd7, 5'd3);
        check("add_result", Result_out, 32'd12);
        check("add_rd", 32'(RdAddr_out), 32'd3);
        check("add_rw", 32'(RegWrite_out), 32'd1);

        rtype(6'h22, 5'd0, 32'd3, 32'd5, 5'd4);
        check("sub_wrap", Result_out, 32'hFFFF_FFFE);
        rtype(6'h2A, 5'd0, 32'hFFFF_FFFF, 32'd1, 5'd4);
        check("slt_signed", Result_out, 32'd1);
        rtype(6'h2A, 5'd0, 32'd1, 32'hFFFF_FFFF, 5'd4);
        check("slt_false", Result_out, 32'd0);
        rtype(6'h24, 5'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd5);
        check("and", Result_out, 32'h00F0_1200);
        step(1'b1, 2'b11, 6'h3F, 5'd0, 32'h0000_00F0, 32'h0000_000F, 5'd6, 1'b1);
        check("aluop_or", Result_out, 32'h0000_00FF);
        step(1'b1, 2'b00, 6'h3F, 5'd0, 32'hFFFF_FFFF, 32'd2, 5'd6, 1'b1);
        check("aluop_add_wrap", Result_out, 32'd1);
        step(1'b1, 2'b01, 6'h3F, 5'd0, 32'd10, 32'd3, 5'd6, 1'b0);
        check("aluop_sub", Result_out, 32'd7);
        check("rw_follows_in", 32'(RegWrite_out), 32'd0);

        rtype(6'h00, 5'd4, 32'h0, 32'd1, 5'd7);
        check("sll", Result_out, 32'h10);
        rtype(6'h02, 5'd31, 32'h0, 32'h8000_0000, 5'd7);
        check("srl_logical", Result_out, 32'h1);
        rtype(6'h00, 5'd0, 32'h0, 32'hA5A5_5A5A, 5'd7);
        check("sll_zero", Result_out, 32'hA5A5_5A5A);
        rtype(6'h3F, 5'd0, 32'd1, 32'd1, 5'd8);
        check("unknown_rw", 32'(RegWrite_out), 32'd0);
        check("unknown_result", Result_out, 32'd0);

        rtype(6'h20, 5'd0, 32'h100, 32'h23, 5'd10);
        check("pre_bubble", Result_out, 32'h123);
        for (int i = 0; i < 3; i++) begin
            bubble();
            check($sformatf("bubble%0d_rw", i), 32'(RegWrite_out), 32'd0);
            check($sformatf("bubble%0d_hold", i), Result_out, 32'h123);
        end
        check("bubble_rd_hold", 32'(RdAddr_out), 32'd10);

        run_multu("mul1", 32'hFFFF_FFFF, 32'd2);
        rtype(6'h10, 5'd0, 32'h0, 32'h0, 5'd11);
        check("mfhi1", Result_out, 32'h1);
        check("mfhi1_rw", 32'(RegWrite_out), 32'd1);
        rtype(6'h12, 5'd0, 32'h0, 32'h0, 5'd12);
        check("mflo1", Result_out, 32'hFFFF_FFFE);

        run_multu("mul2", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_multu("mul3", 32'h1234_5678, 32'h10);
        rtype(6'h10, 5'd0, 32'h0, 32'h0, 5'd11);
        check("mfhi3", Result_out, 32'h1);
        rtype(6'h12, 5'd0, 32'h0, 32'h0, 5'd12);
        check("mflo3", Result_out, 32'h2345_6780);

        run_multu("mul4", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rtype(6'h10, 5'd0, 32'h0, 32'h0, 5'd11);
        check("mfhi4", Result_out, 32'hFFFF_FFFE);
        rtype(6'h12, 5'd0, 32'h0, 32'h0, 5'd12);
        check("mflo4", Result_out, 32'h0000_0001);

        // Abort a multiply at iteration 10.
        rtype(6'h19, 5'd0, 32'hFFFF_FFFF, 32'd3, 5'd9);
        check("abort_stall_on", 32'(stall_out), 32'd1);
        valid_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_still_busy", 32'(stall_out), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_stall_off", 32'(stall_out), 32'd0);
        check("abort_result", Result_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rtype(6'h10, 5'd0, 32'h0, 32'h0, 5'd11);
        check("abort_mfhi", Result_out, 32'h0);
        rtype(6'h12, 5'd0, 32'h0, 32'h0, 5'd12);
        check("abort_mflo", Result_out, 32'h0);
        check("abort_mflo_rw", 32'(RegWrite_out), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
